// File: rtl/note_pkg.sv
// Shared constants and FSM state type for the falling-note lane.
//   Y_W        : width of a note's top-edge y position
//   SCREEN_H   : visible lines; a note whose y reaches this has left the screen
//   SPAWN_Y    : y given to a freshly spawned note
//   HIT_Y_MIN/HIT_Y_MAX : inclusive y range judged as a hit
package note_pkg;
    localparam int Y_W       = 10;
    localparam int SCREEN_H  = 480;
    localparam int SPAWN_Y   = 0;
    localparam int HIT_Y_MIN = 360;
    localparam int HIT_Y_MAX = 420;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/note_slot.sv
// One note slot: active flag plus top-edge y register.
//   clk, reset        : clock, async active-high reset
//   load              : spawn a note here (y <= SPAWN_Y, active <= 1)
//   scroll, speed     : move an active note down by speed pixels
//   clear             : retire the note (judged hit); y is held
//   active, y         : registered slot state
//   would_miss        : scrolling this cycle would push the note off screen
//   in_window         : note is active and inside the hit window
module note_slot #(
    parameter int SCREEN_H  = note_pkg::SCREEN_H,
    parameter int SPAWN_Y   = note_pkg::SPAWN_Y,
    parameter int HIT_Y_MIN = note_pkg::HIT_Y_MIN,
    parameter int HIT_Y_MAX = note_pkg::HIT_Y_MAX
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic                     scroll,
    input  logic                     clear,
    input  logic [3:0]               speed,
    output logic                     active,
    output logic [note_pkg::Y_W-1:0] y,
    output logic                     would_miss,
    output logic                     in_window
);
    import note_pkg::*;

    localparam logic [Y_W:0]   SCREEN_H_L = (Y_W+1)'(SCREEN_H);
    localparam logic [Y_W-1:0] SPAWN_Y_L  = Y_W'(SPAWN_Y);
    localparam logic [Y_W-1:0] WIN_LO     = Y_W'(HIT_Y_MIN);
    localparam logic [Y_W-1:0] WIN_HI     = Y_W'(HIT_Y_MAX);

    // One extra bit so a note near the bottom cannot wrap back to the top.
    logic [Y_W:0] sum;

    assign sum        = {1'b0, y} + (Y_W+1)'(speed);
    assign would_miss = active && (sum >= SCREEN_H_L);
    assign in_window  = active && (y >= WIN_LO) && (y <= WIN_HI);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            y      <= '0;
        end else if (clear) begin
            active <= 1'b0;
        end else if (load) begin
            active <= 1'b1;
            y      <= SPAWN_Y_L;
        end else if (scroll && active) begin
            // A note leaving the screen keeps its last on-screen y.
            if (sum >= SCREEN_H_L) active <= 1'b0;
            else                   y      <= sum[Y_W-1:0];
        end
    end
endmodule

// File: rtl/note_lane_scheduler.sv
// Per-lane note sequencer: spawns notes into a pool of slots, scrolls them
// once per frame and judges button presses against the hit window.
//   clk, reset           : clock, async active-high reset
//   start / stop         : IDLE->PLAY / PLAY->DRAIN pulses
//   frame_tick, speed    : per-frame scroll strobe and pixels per frame
//   spawn_req/spawn_ack  : chart request (held) and same-cycle accept
//   press                : debounced player press
//   note_active, note_y_position : per-slot state, slot i at [10i+9:10i]
//   hit_pulse, miss_pulse, bad_press, done : one-cycle registered pulses
//   hit_count, miss_count : saturating counters
//   busy                 : state != IDLE
module note_lane_scheduler #(
    parameter int SLOTS     = 4,
    parameter int SCREEN_H  = note_pkg::SCREEN_H,
    parameter int SPAWN_Y   = note_pkg::SPAWN_Y,
    parameter int HIT_Y_MIN = note_pkg::HIT_Y_MIN,
    parameter int HIT_Y_MAX = note_pkg::HIT_Y_MAX,
    parameter int CNT_W     = 10
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           stop,
    input  logic                           frame_tick,
    input  logic [3:0]                     speed,
    input  logic                           spawn_req,
    output logic                           spawn_ack,
    input  logic                           press,
    output logic [SLOTS-1:0]               note_active,
    output logic [SLOTS*note_pkg::Y_W-1:0] note_y_position,
    output logic                           hit_pulse,
    output logic                           miss_pulse,
    output logic                           bad_press,
    output logic [CNT_W-1:0]               hit_count,
    output logic [CNT_W-1:0]               miss_count,
    output logic                           busy,
    output logic                           done
);
    import note_pkg::*;

    state_t                      state, state_next;
    logic [SLOTS-1:0]            in_window, would_miss;
    logic [SLOTS-1:0]            spawn_mask, load_mask, hit_mask, clear_mask;
    logic [SLOTS-1:0]            scroll_mask, miss_mask;
    logic [SLOTS-1:0][Y_W-1:0]   y_arr;
    logic [Y_W-1:0]              best_y;
    logic                        run, play, judge, found;
    logic [3:0]                  miss_n;
    logic [CNT_W:0]              miss_sum;

    assign run             = (state != IDLE);
    assign play            = (state == PLAY);
    assign busy            = run;
    assign note_y_position = y_arr;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        note_slot #(
            .SCREEN_H (SCREEN_H),
            .SPAWN_Y  (SPAWN_Y),
            .HIT_Y_MIN(HIT_Y_MIN),
            .HIT_Y_MAX(HIT_Y_MAX)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (load_mask[i]),
            .scroll    (scroll_mask[i]),
            .clear     (clear_mask[i]),
            .speed     (speed),
            .active    (note_active[i]),
            .y         (y_arr[i]),
            .would_miss(would_miss[i]),
            .in_window (in_window[i])
        );
    end

    // Lowest-index free slot. Uses the registered active mask, so a slot
    // retired this cycle only becomes spawnable next cycle.
    always_comb begin
        spawn_mask = '0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!note_active[i]) begin
                spawn_mask    = '0;
                spawn_mask[i] = 1'b1;
            end
        end
    end

    // Handshake ack is combinational so a held request is accepted once.
    assign spawn_ack = play && spawn_req && (|(~note_active));
    assign load_mask = spawn_ack ? spawn_mask : '0;

    // Judge: deepest note in the window wins; strict '>' keeps the lower
    // index on ties.
    always_comb begin
        hit_mask = '0;
        best_y   = '0;
        found    = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (in_window[i] && (!found || y_arr[i] > best_y)) begin
                hit_mask    = '0;
                hit_mask[i] = 1'b1;
                best_y      = y_arr[i];
                found       = 1'b1;
            end
        end
    end

    assign judge       = run && press;
    assign clear_mask  = judge ? hit_mask : '0;
    assign scroll_mask = (run && frame_tick) ? (note_active & ~clear_mask) : '0;
    assign miss_mask   = scroll_mask & would_miss;

    always_comb begin
        miss_n = '0;
        for (int i = 0; i < SLOTS; i++) miss_n = miss_n + 4'(miss_mask[i]);
    end

    assign miss_sum = {1'b0, miss_count} + (CNT_W+1)'(miss_n);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start)        state_next = PLAY;
            PLAY:    if (stop)         state_next = DRAIN;
            DRAIN:   if (~|note_active) state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_pulse  <= 1'b0;
            miss_pulse <= 1'b0;
            bad_press  <= 1'b0;
            done       <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            hit_pulse  <= judge && found;
            bad_press  <= judge && !found;
            miss_pulse <= |miss_mask;
            done       <= (state == DRAIN) && ~|note_active;
            if (state == IDLE && start) begin
                hit_count  <= '0;
                miss_count <= '0;
            end else begin
                if (judge && found && hit_count != '1)
                    hit_count <= hit_count + 1'b1;
                if (miss_sum[CNT_W]) miss_count <= '1;
                else                 miss_count <= miss_sum[CNT_W-1:0];
            end
        end
    end
endmodule

// File: doc/note_lane_scheduler.md
Name: note_lane_scheduler

Overview:
Per-lane sequencer for falling notes. Owns a small pool of note slots (active flag plus top-edge y position). It accepts spawn requests from the chart player, scrolls active notes down once per video frame, and judges player presses against a hit window. Its per-slot y/active outputs drive one note_generator-style visibility instance per slot, with column_start supplied by the lane.

Parameters:
SLOTS, 4, number of concurrent notes in the lane (2..8)
SCREEN_H, 480, visible lines; a note whose y reaches this is missed
SPAWN_Y, 0, y loaded into a newly spawned slot
HIT_Y_MIN, 360, lowest y (inclusive) counted as a hit
HIT_Y_MAX, 420, highest y (inclusive) counted as a hit
CNT_W, 10, width of hit/miss counters

Ports:
clk  in  1  system/pixel clock
reset  in  1  asynchronous, active-high
start  in  1  pulse; IDLE->PLAY
stop  in  1  pulse; PLAY->DRAIN
frame_tick  in  1  one-cycle pulse per frame (vsync)
speed  in  4  pixels per frame added to each active note
spawn_req  in  1  chart requests a new note; held until acked
spawn_ack  out  1  one-cycle accept pulse
press  in  1  one-cycle debounced button pulse
note_active  out  SLOTS  per-slot active flag
note_y_position  out  SLOTS*10  slot i at bits [10i+9:10i]
hit_pulse  out  1  press matched a note
miss_pulse  out  1  at least one note left the screen this cycle
bad_press  out  1  press with no note in the window
hit_count  out  CNT_W  saturating
miss_count  out  CNT_W  saturating; counts notes, not pulses
busy  out  1  state != IDLE
done  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset (async, active-high): state=IDLE; every note_active=0; every y=0; counters=0; all pulses=0.
- FSM: IDLE --start--> PLAY (counters cleared on this transition). PLAY --stop--> DRAIN. DRAIN --no slot active--> IDLE, with done=1 for that cycle. start is ignored outside IDLE; stop is ignored outside PLAY.
- Spawn (PLAY only):
  - spawn_ack=1 in the same cycle spawn_req=1 and a free slot exists in the pre-cycle free mask.
  - Target is the lowest-index free slot: y<=SPAWN_Y, active<=1.
  - Slots freed this cycle are not reusable until the next cycle.
  - No free slot: ack=0 and the request stalls with no drop.
  - In IDLE and DRAIN, ack=0.
- Scroll (PLAY or DRAIN, on frame_tick):
  - Each slot active before the cycle gets y<=y+speed, computed at 11 bits.
  - If the sum is >=SCREEN_H, the slot clears, the y register holds its old value, miss_count increases by the number of slots cleared (saturating), and miss_pulse=1.
  - A slot spawned in the same cycle is not scrolled.
- Judge (PLAY or DRAIN, on press):
  - Candidates are pre-cycle active slots with HIT_Y_MIN<=y<=HIT_Y_MAX, using pre-scroll y.
  - Winner is the candidate with the largest y; ties go to the lower index. The winner clears, hit_pulse=1, and hit_count increments (saturating).
  - No candidate: bad_press=1.
  - A judged slot is neither scrolled nor counted as missed that cycle.
- Outputs are registered. Pulses are high for exactly one cycle, one cycle after the causing input.
- Counters saturate at 2^CNT_W-1.
- Reset mid-operation: immediate return to reset values, with no done pulse.

Decomposition:
- Shared package note_pkg:
  - SCREEN_H, HIT_Y_MIN, HIT_Y_MAX, SPAWN_Y, Y_W=10 constants.
  - FSM state enum {IDLE, PLAY, DRAIN}.
- One natural sub-module: note_slot (single slot register). Inputs: load, scroll with speed, clear. Outputs: active, y, would_miss, in_window.
- The scheduler instantiates SLOTS copies and contains the priority encoders, FSM and counters.

Test Plan:
1. reset, start, spawn_req held 6 cycles with SLOTS=4 -> exactly 4 acks to slots 0,1,2,3, then ack=0 and the request stalls; note_active=4'b1111.
2. one note, speed=8, 60 frame_ticks -> y=480 is reached at tick 60: slot clears, miss_pulse once, miss_count=1; no change at tick 59 (y=472).
3. note at y=376, press -> hit_pulse, slot 0 cleared, hit_count=1. Press with the only note at y=352 -> bad_press, note unchanged.
4. slots with y=370 and y=400, press coincident with frame_tick (speed=8) -> y=400 slot hit; other slot becomes 378; no miss.
5. press and spawn in the same cycle with all slots full and one in window -> hit; ack=0 that cycle; ack next cycle into the freed slot.
6. stop with 2 active notes -> no further acks; done pulse one cycle after the last note exits; busy=0. Assert reset mid-DRAIN -> everything zero, no done.
